stepper_io: RTL and testbench

Memory-mapped stepper-motor peripheral: the responder on the processor's data-memory bus and the driver on the six JA pins. Processor stores program move count, step period and mode; the block steps the coil pattern on JA at a fixed cadence. Processor loads read back status, remaining steps and absolute position. It sits beside `RAM` in `Wrapper`. The wrapper decodes the address range and muxes `rd_data` into `q_dmem` when `rd_hit` is high.

---
 rtl/stepper_pkg.sv | 26 ++
 rtl/stepper_phase_seq.sv | 37 +++
 rtl/stepper_io.sv | 142 ++++++++++++++
 tb/tb_stepper_io.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// Shared constants for the stepper peripheral: register map, CTRL bits,
// coil phase table and sequencer state encoding.
package stepper_pkg;

    localparam logic [2:0] OFF_STEPS  = 3'd0;
    localparam logic [2:0] OFF_PERIOD = 3'd1;
    localparam logic [2:0] OFF_CTRL   = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_POS    = 3'd4;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_DIR  = 1;
    localparam int CTRL_HALF = 2;

    // Entry 0 is the rightmost element: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
    localparam logic [7:0][3:0] PHASE_TABLE = {
        4'b1001, 4'b0001, 4'b0011, 4'b0010,
        4'b0110, 4'b0100, 4'b1100, 4'b1000
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/stepper_phase_seq.sv
// Coil phase index with +/-1 (half) or +/-2 (full) mod-8 advance; exposes the
// pattern the coils will show after the current edge.
module stepper_phase_seq
    import stepper_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       step_i,
    input  logic       dir_i,
    input  logic       half_i,
    output logic [3:0] phase_next_o
);

    logic [2:0] index_q;
    logic [2:0] index_d;
    logic [2:0] delta;

    // 3-bit arithmetic wraps mod 8; a full step of 2 keeps the index parity.
    always_comb begin
        delta   = half_i ? 3'd1 : 3'd2;
        index_d = index_q;
        if (step_i) begin
            index_d = dir_i ? (index_q + delta) : (index_q - delta);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            index_q <= 3'd0;
        end else begin
            index_q <= index_d;
        end
    end

    assign phase_next_o = PHASE_TABLE[index_d];

endmodule

// File: rtl/stepper_io.sv
// Memory-mapped stepper driver: bus decode, config/status registers, step
// cadence timer, move counter, absolute position and the JA pin register.
module stepper_io
    import stepper_pkg::*;
#(
    parameter logic [11:0] BASE           = 12'hFF0,
    parameter logic [23:0] DEFAULT_PERIOD = 24'd100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wren,
    input  logic [11:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rd_hit,
    output logic [5:0]  JA
);

    state_e      state_q, state_d;
    logic [23:0] tick_q, tick_d;
    logic [15:0] remaining_q, remaining_d;
    logic [31:0] pos_q, pos_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [23:0] period_q, period_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_hit_q;
    logic [5:0]  ja_q, ja_d;

    logic [11:0] offset;
    logic [2:0]  reg_sel;
    logic        in_range;
    logic        wr_steps, wr_period, wr_ctrl, wr_pos;
    logic [23:0] period_eff;
    logic        step_fire;
    logic [3:0]  phase_next;
    logic        unused_wr_bits;

    assign offset    = addr - BASE;
    assign reg_sel   = offset[2:0];
    assign in_range  = (offset < 12'd5);
    assign wr_steps  = wren && in_range && (reg_sel == OFF_STEPS);
    assign wr_period = wren && in_range && (reg_sel == OFF_PERIOD);
    assign wr_ctrl   = wren && in_range && (reg_sel == OFF_CTRL);
    assign wr_pos    = wren && in_range && (reg_sel == OFF_POS);

    assign unused_wr_bits = ^wr_data[31:24];

    assign period_eff = (period_q == 24'd0) ? 24'd1 : period_q;
    assign step_fire  = (state_q == ST_RUN) && ctrl_q[CTRL_EN] && (tick_q == 24'd0);

    stepper_phase_seq u_phase (
        .clock        (clock),
        .reset        (reset),
        .step_i       (step_fire),
        .dir_i        (ctrl_q[CTRL_DIR]),
        .half_i       (ctrl_q[CTRL_HALF]),
        .phase_next_o (phase_next)
    );

    // Bus writes are applied after the step update so a STEPS write overrides
    // the decrement and a POS write overrides the step increment.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        remaining_d = remaining_q;
        pos_d       = pos_q;
        ctrl_d      = ctrl_q;
        period_d    = period_q;

        if ((state_q == ST_RUN) && ctrl_q[CTRL_EN]) begin
            if (step_fire) begin
                tick_d      = period_eff - 24'd1;
                remaining_d = remaining_q - 16'd1;
                pos_d       = ctrl_q[CTRL_DIR] ? (pos_q + 32'd1) : (pos_q - 32'd1);
                if (remaining_q == 16'd1) begin
                    state_d = ST_IDLE;
                end
            end else begin
                tick_d = tick_q - 24'd1;
            end
        end

        if (wr_steps) begin
            remaining_d = wr_data[15:0];
            if (wr_data[15:0] == 16'd0) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_RUN;
                if (state_q == ST_IDLE) begin
                    tick_d = period_eff - 24'd1;
                end
            end
        end
        if (wr_period) period_d = wr_data[23:0];
        if (wr_ctrl)   ctrl_d   = wr_data[2:0];
        if (wr_pos)    pos_d    = 32'd0;
    end

    always_comb begin
        rd_data_d = 32'd0;
        if (in_range) begin
            case (reg_sel)
                OFF_PERIOD: rd_data_d = {8'd0, period_q};
                OFF_CTRL:   rd_data_d = {29'd0, ctrl_q};
                OFF_STATUS: rd_data_d = {remaining_q, 15'd0, (state_q == ST_RUN)};
                OFF_POS:    rd_data_d = pos_q;
                default:    rd_data_d = 32'd0;
            endcase
        end
    end

    assign ja_d = ctrl_d[CTRL_EN] ? {2'b11, phase_next} : 6'd0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            tick_q      <= 24'd0;
            remaining_q <= 16'd0;
            pos_q       <= 32'd0;
            ctrl_q      <= 3'd0;
            period_q    <= DEFAULT_PERIOD;
            rd_data_q   <= 32'd0;
            rd_hit_q    <= 1'b0;
            ja_q        <= 6'd0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            remaining_q <= remaining_d;
            pos_q       <= pos_d;
            ctrl_q      <= ctrl_d;
            period_q    <= period_d;
            rd_data_q   <= rd_data_d;
            rd_hit_q    <= in_range;
            ja_q        <= ja_d;
        end
    end

    assign rd_data = rd_data_q;
    assign rd_hit  = rd_hit_q;
    assign JA      = ja_q;

endmodule

// File: tb/tb_stepper_io.sv
// Bench for stepper_io: register-map vector table, directed move sequences and
// randomized bus traffic compared every cycle against a behavioural model.
module tb_stepper_io;

    localparam logic [11:0] BASE = 12'hFF0;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        wren = 1'b0;
    logic [11:0] addr = 12'd0;
    logic [31:0] wr_data = 32'd0;
    logic [31:0] rd_data;
    logic        rd_hit;
    logic [5:0]  JA;

    stepper_io #(.BASE(BASE), .DEFAULT_PERIOD(24'd100000)) dut (
        .clock   (clock),
        .reset   (reset),
        .wren    (wren),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .rd_hit  (rd_hit),
        .JA      (JA)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] tbl [0:7];

    // Model: a move counts enabled cycles and steps when the count reaches the
    // period latched at the start of that interval.
    bit          m_busy;
    logic [15:0] m_rem;
    int          m_cnt, m_target, m_idx, m_pos;
    logic [23:0] m_period;
    logic [2:0]  m_ctrl;
    logic [31:0] m_rd;
    logic        m_hit;
    logic [5:0]  m_ja;

    typedef struct {
        logic        we;
        logic [11:0] a;
        logic [31:0] d;
        logic        hit;
        logic [31:0] rd;
    } vec_t;
    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic we, input logic [11:0] a, input logic [31:0] d);
        int  ra, p_eff, sgn;
        bit  step;
        if (rst) begin
            m_busy = 0; m_rem = 0; m_cnt = 0; m_target = 1; m_idx = 0; m_pos = 0;
            m_period = 24'd100000; m_ctrl = 0; m_rd = 0; m_hit = 0; m_ja = 0;
            return;
        end
        ra    = int'(a) - int'(BASE);
        m_hit = (ra >= 0 && ra <= 4);
        m_rd  = 0;
        if (m_hit) begin
            case (ra)
                1: m_rd = 32'(m_period);
                2: m_rd = 32'(m_ctrl);
                3: m_rd = {m_rem, 15'd0, m_busy};
                4: m_rd = m_pos;
                default: m_rd = 0;
            endcase
        end
        p_eff = (m_period == 0) ? 1 : int'(m_period);
        step  = 0;
        if (m_busy && m_ctrl[0]) begin
            m_cnt++;
            if (m_cnt >= m_target) step = 1;
        end
        if (step) begin
            sgn    = m_ctrl[1] ? 1 : -1;
            m_idx  = (m_idx + sgn * (m_ctrl[2] ? 1 : 2) + 8) % 8;
            m_pos += sgn;
            m_rem  = m_rem - 16'd1;
            m_cnt  = 0;
            m_target = p_eff;
            if (m_rem == 0) m_busy = 0;
        end
        if (we && m_hit) begin
            case (ra)
                0: begin
                    if (d[15:0] == 0) begin
                        m_rem = 0; m_busy = 0;
                    end else begin
                        if (!m_busy) begin m_cnt = 0; m_target = p_eff; end
                        m_busy = 1; m_rem = d[15:0];
                    end
                end
                1: m_period = d[23:0];
                2: m_ctrl = d[2:0];
                4: m_pos = 0;
                default: ;
            endcase
        end
        m_ja = m_ctrl[0] ? {2'b11, tbl[m_idx]} : 6'd0;
    endtask

    task automatic cyc(input logic rst, input logic we, input logic [11:0] a, input logic [31:0] d);
        reset = rst; wren = we; addr = a; wr_data = d;
        model_edge(rst, we, a, d);
        @(posedge clock);
        #1;
        chk("ja", 32'(JA), 32'(m_ja));
        chk("rd_hit", 32'(rd_hit), 32'(m_hit));
        chk("rd_data", rd_data, m_rd);
        reset = 0; wren = 0; addr = 0; wr_data = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 12'd0, 32'd0);
    endtask

    task automatic wr(input int off, input logic [31:0] d);
        cyc(0, 1, BASE + 12'(off), d);
    endtask

    task automatic rd(input int off);
        cyc(0, 0, BASE + 12'(off), 32'd0);
    endtask

    initial begin
        logic [11:0] ra;
        logic [31:0] rdat;
        int          r, off;

        tbl = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};

        vecs[0]  = '{1'b0, 12'hFF3, 32'h0,          1'b1, 32'h0};
        vecs[1]  = '{1'b0, 12'hFF1, 32'h0,          1'b1, 32'h0001_86A0};
        vecs[2]  = '{1'b0, 12'hFF4, 32'h0,          1'b1, 32'h0};
        vecs[3]  = '{1'b0, 12'hFF0, 32'h0,          1'b1, 32'h0};
        vecs[4]  = '{1'b0, 12'hFF5, 32'h0,          1'b0, 32'h0};
        vecs[5]  = '{1'b0, 12'hFEF, 32'h0,          1'b0, 32'h0};
        vecs[6]  = '{1'b1, 12'hFF1, 32'hABCD_EF07,  1'b1, 32'h0001_86A0};
        vecs[7]  = '{1'b0, 12'hFF1, 32'h0,          1'b1, 32'h00CD_EF07};
        vecs[8]  = '{1'b1, 12'hFF2, 32'hFFFF_FFFE,  1'b1, 32'h0};
        vecs[9]  = '{1'b0, 12'hFF2, 32'h0,          1'b1, 32'h6};
        vecs[10] = '{1'b1, 12'hFF3, 32'hFFFF_FFFF,  1'b1, 32'h0};
        vecs[11] = '{1'b0, 12'hFF3, 32'h0,          1'b1, 32'h0};
        vecs[12] = '{1'b1, 12'hFF4, 32'h0000_1234,  1'b1, 32'h0};
        vecs[13] = '{1'b0, 12'hFF4, 32'h0,          1'b1, 32'h0};
        vecs[14] = '{1'b0, 12'h000, 32'h0,          1'b0, 32'h0};
        vecs[15] = '{1'b0, 12'hFF2, 32'h0,          1'b1, 32'h6};

        cyc(1, 0, 12'd0, 32'd0);
        cyc(1, 0, 12'd0, 32'd0);
        chk("reset_ja", 32'(JA), 32'd0);
        for (int i = 0; i < 16; i++) begin
            cyc(0, vecs[i].we, vecs[i].a, vecs[i].d);
            chk($sformatf("vec%0d_hit", i), 32'(rd_hit), 32'(vecs[i].hit));
            chk($sformatf("vec%0d_rd", i), rd_data, vecs[i].rd);
        end
        idle(1);
        chk("hit_one_cycle", 32'(rd_hit), 32'd0);

        // Full step forward, period 4, three steps
        cyc(1, 0, 12'd0, 32'd0);
        wr(2, 32'd3); wr(1, 32'd4); wr(0, 32'd3);
        idle(3); chk("t1_hold", 32'(JA), 32'(6'b111000));
        idle(1); chk("t1_step1", 32'(JA), 32'(6'b110100));
        idle(4); chk("t1_step2", 32'(JA), 32'(6'b110010));
        idle(3); rd(3);
        chk("t1_busy_before_last", rd_data, 32'h0001_0001);
        chk("t1_step3", 32'(JA), 32'(6'b110001));
        rd(3); chk("t1_done", rd_data, 32'd0);
        rd(4); chk("t1_pos", rd_data, 32'd3);

        // Half step reverse, period 1
        cyc(1, 0, 12'd0, 32'd0);
        wr(1, 32'd1); wr(2, 32'd5); wr(0, 32'd2);
        idle(1); chk("t2_step1", 32'(JA), 32'(6'b111001));
        idle(1); chk("t2_step2", 32'(JA), 32'(6'b110001));
        rd(4); chk("t2_pos", rd_data, 32'hFFFF_FFFE);

        // Pause and resume
        cyc(1, 0, 12'd0, 32'd0);
        wr(1, 32'd5); wr(2, 32'd3); wr(0, 32'd10);
        idle(10);
        wr(2, 32'd2);
        chk("t3_ja_off", 32'(JA), 32'd0);
        idle(10); rd(3); chk("t3_rem_a", rd_data, 32'h0008_0001);
        idle(10); rd(3); chk("t3_rem_b", rd_data, 32'h0008_0001);
        wr(2, 32'd3);
        rdat = 32'hFFFF_FFFF;
        for (int i = 0; i < 200; i++) begin
            rd(3);
            rdat = rd_data;
            if (rdat[0] == 1'b0) break;
        end
        chk("t3_finished", rdat, 32'd0);
        rd(4); chk("t3_pos", rd_data, 32'd10);

        // STEPS write colliding with a step, then STEPS = 0 mid-move
        cyc(1, 0, 12'd0, 32'd0);
        wr(1, 32'd4); wr(2, 32'd3); wr(0, 32'd10);
        idle(3); wr(0, 32'd5);
        chk("t4_step_fired", 32'(JA), 32'(6'b110100));
        rd(3); chk("t4_rem", rd_data, 32'h0005_0001);
        wr(0, 32'd0);
        rd(3); chk("t4_stopped", rd_data, 32'd0);
        idle(10); chk("t4_ja_frozen", 32'(JA), 32'(6'b110100));
        rd(4); chk("t4_pos", rd_data, 32'd1);

        // Reset mid-move
        wr(0, 32'd50);
        idle(9);
        cyc(1, 0, 12'd0, 32'd0);
        chk("t5_ja", 32'(JA), 32'd0);
        rd(3); chk("t5_status", rd_data, 32'd0);
        rd(4); chk("t5_pos", rd_data, 32'd0);

        // Randomized traffic against the model
        cyc(1, 0, 12'd0, 32'd0);
        wr(1, 32'd2);
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 199);
            if ($urandom_range(0, 9) < 8) ra = BASE + 12'($urandom_range(0, 5));
            else ra = 12'($urandom);
            if (r == 0) begin
                cyc(1, 0, 12'd0, 32'd0);
                wr(1, 32'($urandom_range(0, 5)));
            end else if (r < 110) begin
                cyc(0, 0, ra, $urandom);
            end else if (r < 120) begin
                cyc(0, 1, ra, $urandom);
            end else begin
                off = $urandom_range(0, 4);
                case (off)
                    0: wr(0, ($urandom_range(0, 15) == 0) ? 32'd0 : 32'($urandom_range(1, 12)));
                    1: wr(1, 32'($urandom_range(0, 5)));
                    default: wr(off, $urandom);
                endcase
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
